stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
- Button sequencer for the stopwatch datapath. Converts two raw push-buttons (start/stop, lap/clear) into clean control for the counter and the display path.
- Controls generated: run enable, clear pulse, lap-capture pulse, display-freeze flag.
- Sits between the board buttons and the stopwatch counter / 7-seg driver.
- Synchroniser and debounce are contained inside this block.

Parameters:
- DB_CYCLES, 1000000, consecutive stable cycles needed to accept a new button level (10 ms at 100 MHz).
- HOLD_CYCLES, 200000000, debounced-high cycles on lap button that make a long press (2 s at 100 MHz).

Ports:
- clk  in  1  system clock; the block has one clock.
- rst  in  1  reset. Synchronous, active-high.
- btn_ss  in  1  raw start/stop button. Asynchronous and bouncing; high = pressed.
- btn_lap  in  1  raw lap/clear button. Asynchronous and bouncing; high = pressed.
- run  out  1  count enable to the stopwatch counter.
- clr  out  1  one-cycle pulse; zeroes the stopwatch count.
- lap_latch  out  1  one-cycle pulse; display latch captures the current time.
- disp_freeze  out  1  1 = display shows the latched value; 0 = display shows the live count.
- state  out  2  FSM state for LED/debug: IDLE=00, RUN=01, LAP=10, PAUSE=11.

Behaviour:
- Reset (synchronous, rst=1 at an edge):
  - state=IDLE; run=0, clr=0, lap_latch=0, disp_freeze=0.
  - Synchroniser flops, debounced levels, debounce counters and hold counter all cleared.
  - rst mid-operation returns to IDLE on that edge and does not pulse clr.
- Input conditioning, per button:
  - Two-flop synchroniser.
  - Debounce counter increments while the synchronised value differs from the debounced level. It returns to 0 on any cycle where they are equal.
  - When the count reaches DB_CYCLES-1 and the values still differ, the debounced level takes the new value and the counter clears.
  - Glitches shorter than DB_CYCLES cycles are never accepted.
- Events (each a single cycle, combinational from debounced levels plus hold counter):
  - ss_press: rising edge of debounced btn_ss.
  - lap_long: fires when the hold counter reaches HOLD_CYCLES-1 while debounced lap is high.
    - The hold counter saturates after this.
    - lap_long fires once per hold.
  - lap_short: falling edge of debounced lap, only if lap_long did not fire during that hold.
  - The hold counter clears when debounced lap is low.
- Latency:
  - A clean raw step on btn_ss, applied before edge 0, updates run at edge DB_CYCLES+3.
  - A lap release acts with the same latency, measured from the release.
- FSM (registered; outputs are registered with the state):
  - IDLE: run=0, freeze=0.
    - ss_press -> RUN.
    - lap_long -> IDLE, clr pulse.
    - lap_short ignored.
  - RUN: run=1, freeze=0.
    - ss_press -> PAUSE.
    - lap_short -> LAP, lap_latch pulse.
    - lap_long ignored (no clear while counting).
  - LAP: run=1, freeze=1.
    - lap_short -> LAP, new lap_latch pulse (next split).
    - lap_long -> RUN (live display restored).
    - ss_press -> PAUSE.
  - PAUSE: run=0, freeze=0.
    - ss_press -> RUN.
    - lap_long -> IDLE, clr pulse.
    - lap_short ignored.
- Simultaneous ss_press and a lap event in the same cycle: ss_press wins and the lap event is discarded.
- Both buttons held: each button is debounced independently, with no interaction.
- clr and lap_latch are never high in the same cycle. Each is high for exactly one cycle per event.

Optional Feature:
- Macro STOPWATCH_LAP_EN.
- Defined: LAP state, lap_short handling, lap_latch and disp_freeze behave as above.
- Undefined:
  - LAP state is unreachable.
  - lap_latch and disp_freeze are tied to 0.
  - lap_short has no effect.
  - The lap debounce and hold path is kept, because lap_long (clear) is still required.

Test Plan (DB_CYCLES=4, HOLD_CYCLES=20):
- Reset with rst=1 for 2 edges -> state=00, run=0, clr=0, lap_latch=0, disp_freeze=0.
- btn_ss 0->1 cleanly before edge 0 -> run=1 and state=01 exactly at edge 7. Release, then press again -> state=11, run=0.
- btn_ss toggling every cycle for 30 cycles, then held 0 -> no state change, run stays 0. Repeat with 3-cycle pulses -> still no change.
- In RUN: lap held 8 cycles then released -> one lap_latch pulse, state=10, freeze=1. Second short press -> second pulse, state stays 10. Long hold (25 cycles) -> state=01, freeze=0, no pulse.
- In PAUSE: lap held 25 cycles -> exactly one clr pulse, state=00. Nothing further happens on release. Same long hold in RUN -> no clr, state stays 01.
- ss_press and lap_short aligned to the same cycle in RUN -> state=11, no lap_latch. Under the build without STOPWATCH_LAP_EN, short lap in RUN -> state stays 01 and lap_latch stays 0.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Stopwatch button sequencer: synchronise, debounce and decode start/stop and lap/clear
// buttons into run/clear/lap-latch/freeze controls. Optional lap splits: STOPWATCH_LAP_EN.
module stopwatch_ctrl #(
    parameter int unsigned DB_CYCLES   = 1000000,
    parameter int unsigned HOLD_CYCLES = 200000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_ss,
    input  logic       btn_lap,
    output logic       run,
    output logic       clr,
    output logic       lap_latch,
    output logic       disp_freeze,
    output logic [1:0] state
);

    localparam int unsigned DB_W   = $clog2(DB_CYCLES + 1);
    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        LAP   = 2'b10,
        PAUSE = 2'b11
    } state_t;

    // Bit 0 = start/stop, bit 1 = lap/clear
    logic [1:0]      sync1;
    logic [1:0]      sync2;
    logic [1:0]      deb;
    logic [DB_W-1:0] db_cnt [2];

    logic              ss_prev;
    logic [HOLD_W-1:0] hold_cnt;
    logic              long_done;

    logic ss_press;
    logic lap_long;
    logic ss_ev;
    logic long_ev;

    state_t state_q;
    state_t state_next;
    logic   clr_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= '0;
            sync2   <= '0;
            deb     <= '0;
            ss_prev <= 1'b0;
            for (int unsigned i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1   <= {btn_lap, btn_ss};
            sync2   <= sync1;
            ss_prev <= deb[0];
            for (int unsigned i = 0; i < 2; i++) begin
                if (sync2[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    deb[i]    <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // Hold counter saturates; long_done suppresses a repeat long event and the release short event
    always_ff @(posedge clk) begin
        if (rst || !deb[1]) begin
            hold_cnt  <= '0;
            long_done <= 1'b0;
        end else begin
            if (hold_cnt != HOLD_LAST) begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
            end
            if (lap_long) begin
                long_done <= 1'b1;
            end
        end
    end

    assign ss_press = deb[0] & ~ss_prev;
    assign lap_long = deb[1] & (hold_cnt == HOLD_LAST) & ~long_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            ss_ev   <= 1'b0;
            long_ev <= 1'b0;
        end else begin
            ss_ev   <= ss_press;
            long_ev <= lap_long;
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic lap_prev;
    logic lap_short;
    logic short_ev;
    logic latch_next;

    assign lap_short = ~deb[1] & lap_prev & ~long_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            lap_prev <= 1'b0;
            short_ev <= 1'b0;
        end else begin
            lap_prev <= deb[1];
            short_ev <= lap_short;
        end
    end
`endif

    // Priority: start/stop first, then long lap, then short lap
    always_comb begin
        state_next = state_q;
        clr_next   = 1'b0;
`ifdef STOPWATCH_LAP_EN
        latch_next = 1'b0;
`endif
        if (ss_ev) begin
            case (state_q)
                IDLE, PAUSE: state_next = RUN;
                default:     state_next = PAUSE;
            endcase
        end else if (long_ev) begin
            case (state_q)
                IDLE, PAUSE: begin
                    state_next = IDLE;
                    clr_next   = 1'b1;
                end
                LAP:     state_next = RUN;
                default: state_next = state_q;
            endcase
        end
`ifdef STOPWATCH_LAP_EN
        else if (short_ev && (state_q == RUN || state_q == LAP)) begin
            state_next = LAP;
            latch_next = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            run     <= 1'b0;
            clr     <= 1'b0;
        end else begin
            state_q <= state_next;
            run     <= (state_next == RUN) || (state_next == LAP);
            clr     <= clr_next;
        end
    end

`ifdef STOPWATCH_LAP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            lap_latch   <= 1'b0;
            disp_freeze <= 1'b0;
        end else begin
            lap_latch   <= latch_next;
            disp_freeze <= (state_next == LAP);
        end
    end
`else
    assign lap_latch   = 1'b0;
    assign disp_freeze = 1'b0;
`endif

    assign state = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed self-checking bench for stopwatch_ctrl with DB_CYCLES=4, HOLD_CYCLES=20.
// Lap-split expectations follow STOPWATCH_LAP_EN when the bench is built with it.
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_ss;
    logic       btn_lap;
    logic       run;
    logic       clr;
    logic       lap_latch;
    logic       disp_freeze;
    logic [1:0] state;

    int checks  = 0;
    int errors  = 0;
    int overlap = 0;

    logic [5:0] obs;
    assign obs = {state, run, clr, lap_latch, disp_freeze};

    always #5 clk = ~clk;

    stopwatch_ctrl #(
        .DB_CYCLES  (4),
        .HOLD_CYCLES(20)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_ss     (btn_ss),
        .btn_lap    (btn_lap),
        .run        (run),
        .clr        (clr),
        .lap_latch  (lap_latch),
        .disp_freeze(disp_freeze),
        .state      (state)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic watch(input int n, output int lat, output int cl);
        lat = 0;
        cl  = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (lap_latch === 1'b1) lat++;
            if (clr === 1'b1) cl++;
            if (lap_latch === 1'b1 && clr === 1'b1) overlap++;
        end
    endtask

    task automatic press_ss();
        btn_ss = 1'b1;
        repeat (8) step();
        btn_ss = 1'b0;
        repeat (10) step();
    endtask

    task automatic test_reset();
        rst = 1'b1; btn_ss = 1'b0; btn_lap = 1'b0;
        step(); step();
        checks++;
        if (obs !== 6'b000000) begin
            errors++; $display("FAIL reset: got %b want 000000", obs);
        end
        rst = 1'b0;
        step();
        checks++;
        if (obs !== 6'b000000) begin
            errors++; $display("FAIL post_reset_idle: got %b want 000000", obs);
        end
    endtask

    task automatic test_glitch();
        int bad = 0;
        for (int i = 0; i < 30; i++) begin
            btn_ss = (i % 2 == 0);
            step();
            if (state !== 2'b00 || run !== 1'b0) bad++;
        end
        btn_ss = 1'b0;
        repeat (10) begin step(); if (state !== 2'b00 || run !== 1'b0) bad++; end
        checks++;
        if (bad !== 0 || obs !== 6'b000000) begin
            errors++; $display("FAIL toggle_glitch: bad=%0d obs=%b want bad=0 obs=000000", bad, obs);
        end
        bad = 0;
        for (int p = 0; p < 5; p++) begin
            btn_ss = 1'b1;
            repeat (3) begin step(); if (state !== 2'b00 || run !== 1'b0) bad++; end
            btn_ss = 1'b0;
            repeat (3) begin step(); if (state !== 2'b00 || run !== 1'b0) bad++; end
        end
        repeat (10) begin step(); if (state !== 2'b00 || run !== 1'b0) bad++; end
        checks++;
        if (bad !== 0 || obs !== 6'b000000) begin
            errors++; $display("FAIL pulse3_glitch: bad=%0d obs=%b want bad=0 obs=000000", bad, obs);
        end
    endtask

    task automatic test_ss_latency();
        btn_ss = 1'b1;
        repeat (7) step();
        checks++;
        if ({state, run} !== 3'b000) begin
            errors++; $display("FAIL ss_edge6: got %b want 000", {state, run});
        end
        step();
        checks++;
        if ({state, run} !== 3'b011) begin
            errors++; $display("FAIL ss_edge7: got %b want 011", {state, run});
        end
        btn_ss = 1'b0;
        repeat (10) step();
        checks++;
        if ({state, run} !== 3'b011) begin
            errors++; $display("FAIL ss_release: got %b want 011", {state, run});
        end
        btn_ss = 1'b1;
        repeat (8) step();
        checks++;
        if (obs !== 6'b110000) begin
            errors++; $display("FAIL ss_pause: got %b want 110000", obs);
        end
        btn_ss = 1'b0;
        repeat (10) step();
    endtask

    task automatic test_lap_split();
        int lat, cl, lat2, cl2;
        logic [5:0] want_split;
        int want_pulse;
`ifdef STOPWATCH_LAP_EN
        want_split = 6'b101001;
        want_pulse = 1;
`else
        want_split = 6'b011000;
        want_pulse = 0;
`endif
        press_ss();
        for (int k = 0; k < 2; k++) begin
            btn_lap = 1'b1;
            repeat (8) step();
            btn_lap = 1'b0;
            watch(12, lat, cl);
            checks++;
            if (lat !== want_pulse || cl !== 0) begin
                errors++; $display("FAIL lap_short%0d_pulses: latch=%0d clr=%0d want latch=%0d clr=0", k, lat, cl, want_pulse);
            end
            checks++;
            if (obs !== want_split) begin
                errors++; $display("FAIL lap_short%0d_state: got %b want %b", k, obs, want_split);
            end
        end
        btn_lap = 1'b1;
        watch(25, lat, cl);
        btn_lap = 1'b0;
        watch(12, lat2, cl2);
        checks++;
        if (lat + lat2 !== 0 || cl + cl2 !== 0) begin
            errors++; $display("FAIL lap_long_pulses: latch=%0d clr=%0d want 0 0", lat + lat2, cl + cl2);
        end
        checks++;
        if (obs !== 6'b011000) begin
            errors++; $display("FAIL lap_long_state: got %b want 011000", obs);
        end
    endtask

    task automatic test_pause_clear();
        int lat, cl, lat2, cl2;
        press_ss();
        checks++;
        if (obs !== 6'b110000) begin
            errors++; $display("FAIL pause_entry: got %b want 110000", obs);
        end
        btn_lap = 1'b1;
        watch(25, lat, cl);
        btn_lap = 1'b0;
        watch(12, lat2, cl2);
        checks++;
        if (cl + cl2 !== 1 || lat + lat2 !== 0) begin
            errors++; $display("FAIL pause_clr_once: clr=%0d latch=%0d want 1 0", cl + cl2, lat + lat2);
        end
        checks++;
        if (obs !== 6'b000000) begin
            errors++; $display("FAIL pause_clr_idle: got %b want 000000", obs);
        end
        watch(10, lat, cl);
        checks++;
        if (cl !== 0 || obs !== 6'b000000) begin
            errors++; $display("FAIL clr_release_quiet: clr=%0d obs=%b want 0 000000", cl, obs);
        end
        press_ss();
        btn_lap = 1'b1;
        watch(25, lat, cl);
        btn_lap = 1'b0;
        watch(12, lat2, cl2);
        checks++;
        if (cl + cl2 !== 0 || obs !== 6'b011000) begin
            errors++; $display("FAIL run_long_noclr: clr=%0d obs=%b want 0 011000", cl + cl2, obs);
        end
    endtask

    task automatic test_simultaneous();
        int lat, cl;
        btn_lap = 1'b1;
        repeat (8) step();
        btn_lap = 1'b0;
        btn_ss  = 1'b1;
        watch(12, lat, cl);
        checks++;
        if (lat !== 0 || cl !== 0 || obs !== 6'b110000) begin
            errors++; $display("FAIL simultaneous: latch=%0d clr=%0d obs=%b want 0 0 110000", lat, cl, obs);
        end
        btn_ss = 1'b0;
        repeat (10) step();
    endtask

    task automatic test_reset_mid();
        int lat, cl;
        press_ss();
        checks++;
        if (obs !== 6'b011000) begin
            errors++; $display("FAIL mid_pre_run: got %b want 011000", obs);
        end
        btn_lap = 1'b1;
        repeat (10) step();
        rst = 1'b1;
        step();
        checks++;
        if (obs !== 6'b000000) begin
            errors++; $display("FAIL mid_reset: got %b want 000000", obs);
        end
        rst = 1'b0;
        btn_lap = 1'b0;
        watch(30, lat, cl);
        checks++;
        if (cl !== 0 || lat !== 0 || obs !== 6'b000000) begin
            errors++; $display("FAIL post_mid_reset_quiet: clr=%0d latch=%0d obs=%b want 0 0 000000", cl, lat, obs);
        end
        checks++;
        if (overlap !== 0) begin
            errors++; $display("FAIL clr_latch_overlap: got %0d want 0", overlap);
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_ss_latency();
        test_lap_split();
        test_pause_clear();
        test_simultaneous();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
